// File: rtl/fanout_bcast_ctrl.sv
// Broadcast controller: source words ripple through NUM_STAGES repeater registers and are held at the tail
// until every load has taken them; latency NUM_STAGES cycles, full rate under all-ready, combinational ready chain.
module fanout_bcast_ctrl #(
   parameter int WIDTH      = 8,
   parameter int NUM_LOADS  = 3,
   parameter int NUM_STAGES = 2,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [WIDTH-1:0]     src_data,
   output logic [NUM_LOADS-1:0] load_valid,
   input  logic [NUM_LOADS-1:0] load_ready,
   output logic [WIDTH-1:0]     load_data,
   output logic                 busy,
   output logic [CNT_W-1:0]     bcast_cnt
);

   localparam int TAIL = NUM_STAGES - 1;

   typedef enum logic {S_IDLE, S_BCAST} state_t;

   state_t                 r_state, w_state_nxt;
   logic [NUM_STAGES-1:0]  r_v;
   logic [WIDTH-1:0]       r_d [NUM_STAGES];
   logic [NUM_LOADS-1:0]   r_done, w_done_nxt, w_acc;
   logic [CNT_W-1:0]       r_cnt;

   logic [NUM_STAGES-1:0]  w_adv, w_in_adv;
   logic [WIDTH-1:0]       w_in_dat [NUM_STAGES];
   logic                   w_pop, w_push, w_head_rdy;

   // Tail view: each load sees valid only until it has taken the current word.
   always_comb begin
      load_valid = '0;
      w_acc      = r_done;
      if (r_state == S_BCAST) begin
         load_valid = ~r_done;
         w_acc      = r_done | load_ready;
      end
   end

   assign w_pop = (r_state == S_BCAST) & (&w_acc);

   // Ready ripples from the tail back to the source within the cycle.
   always_comb begin : ready_chain
      logic w_rdy_k;
      logic w_adv_k;
      w_adv       = '0;
      w_adv[TAIL] = w_pop;
      w_rdy_k     = ~r_v[TAIL] | w_pop;
      for (int k = TAIL - 1; k >= 0; k--) begin
         w_adv_k  = r_v[k] & w_rdy_k;
         w_adv[k] = w_adv_k;
         w_rdy_k  = ~r_v[k] | w_adv_k;
      end
      w_head_rdy = w_rdy_k;
   end

   assign src_ready = w_head_rdy & ~flush & rst_n;
   assign w_push    = src_valid & src_ready;

   always_comb begin
      w_in_adv    = '0;
      w_in_adv[0] = w_push;
      w_in_dat[0] = src_data;
      for (int k = 1; k < NUM_STAGES; k++) begin
         w_in_adv[k] = w_adv[k-1];
         w_in_dat[k] = r_d[k-1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = r_done;
      case (r_state)
         S_IDLE: begin
            if (w_in_adv[TAIL]) w_state_nxt = S_BCAST;
         end
         S_BCAST: begin
            if (w_pop) begin
               w_done_nxt  = '0;
               w_state_nxt = w_in_adv[TAIL] ? S_BCAST : S_IDLE;
            end else begin
               w_done_nxt  = w_acc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Flush drops in-flight words but keeps stage data so load_data holds its last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_v     <= '0;
         r_done  <= '0;
         r_cnt   <= '0;
         for (int k = 0; k < NUM_STAGES; k++) r_d[k] <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_v     <= '0;
         r_done  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_in_adv[k]) begin
               r_v[k] <= 1'b1;
               r_d[k] <= w_in_dat[k];
            end else if (w_adv[k]) begin
               r_v[k] <= 1'b0;
            end
         end
      end
   end

   assign load_data = r_d[TAIL];
   assign busy      = |r_v;
   assign bcast_cnt = r_cnt;

endmodule
